// File: rtl/vx_uop_expander_pkg.sv
// Shared definitions for the microcode expander: branch codes, FSM states and
// the micro-op ROM word layout for the default configuration.
package vx_uop_expander_pkg;

    localparam int UOP_DEPTH_DEF = 64;
    localparam int UPC_BITS_DEF  = $clog2(UOP_DEPTH_DEF);
    localparam int CNT_BITS_DEF  = 3;
    localparam int NR_BITS_DEF   = 6;
    localparam int CTRL_W_DEF    = 80;
    localparam int META_W_DEF    = 48;

    localparam logic [1:0] UBR_NEXT   = 2'd0;
    localparam logic [1:0] UBR_FINISH = 2'd1;
    localparam logic [1:0] UBR_LOOP   = 2'd2;
    localparam logic [1:0] UBR_RSVD   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    // ROM word, MSB first; the low CTRL_W + 4*NR_BITS bits match the output word.
    typedef struct packed {
        logic [1:0]              ubr;
        logic [UPC_BITS_DEF-1:0] target;
        logic [CNT_BITS_DEF-1:0] loop_cnt;
        logic [NR_BITS_DEF-1:0]  stride;
        logic [CTRL_W_DEF-1:0]   ctrl;
        logic [NR_BITS_DEF-1:0]  rd;
        logic [NR_BITS_DEF-1:0]  rs1;
        logic [NR_BITS_DEF-1:0]  rs2;
        logic [NR_BITS_DEF-1:0]  rs3;
    } uop_rom_word_t;

    localparam int ROM_W_DEF = $bits(uop_rom_word_t);

endpackage

// File: rtl/vx_uop_rom.sv
// Combinational tensor microcode table. Unlisted addresses decode to FINISH
// with an all-zero payload.
module vx_uop_rom
    import vx_uop_expander_pkg::*;
#(
    parameter int UOP_DEPTH = UOP_DEPTH_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int NR_BITS   = NR_BITS_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    localparam int UPC_BITS = $clog2(UOP_DEPTH),
    localparam int ROM_W    = 2 + UPC_BITS + CNT_BITS + 5 * NR_BITS + CTRL_W
) (
    input  logic [UPC_BITS-1:0] addr_i,
    output logic [ROM_W-1:0]    word_o
);

    function automatic logic [ROM_W-1:0] uop(
        input logic [1:0]  ubr,
        input int unsigned target,
        input int unsigned cnt,
        input int unsigned stride,
        input int unsigned ctrl,
        input int unsigned rd,
        input int unsigned rs1,
        input int unsigned rs2,
        input int unsigned rs3
    );
        return {ubr, UPC_BITS'(target), CNT_BITS'(cnt), NR_BITS'(stride), CTRL_W'(ctrl),
                NR_BITS'(rd), NR_BITS'(rs1), NR_BITS'(rs2), NR_BITS'(rs3)};
    endfunction

    always_comb begin
        word_o = uop(UBR_FINISH, 0, 0, 0, 0, 0, 0, 0, 0);
        case (addr_i)
            UPC_BITS'(0):  word_o = uop(UBR_NEXT,   8,  0, 0, 'h111,  1,  2,  3,  4);
            UPC_BITS'(8):  word_o = uop(UBR_FINISH, 0,  0, 0, 'h222,  5,  6,  7,  8);
            UPC_BITS'(20): word_o = uop(UBR_LOOP,   20, 3, 2, 'h333, 16, 33, 10,  0);
            UPC_BITS'(21): word_o = uop(UBR_FINISH, 0,  0, 0, 'h444,  9, 10, 11, 12);
            UPC_BITS'(30): word_o = uop(UBR_RSVD,   5,  0, 0, 'h666, 13, 14, 15, 16);
            UPC_BITS'(63): word_o = uop(UBR_LOOP,   63, 1, 3, 'h555, 62, 31,  0, 45);
            default:       word_o = uop(UBR_FINISH, 0,  0, 0, 0,      0,  0,  0,  0);
        endcase
    end

endmodule

// File: rtl/vx_uop_expander.sv
// Decode-to-ibuffer microcode expander: passes ordinary instructions through and
// expands macros into ROM micro-op streams behind a single output register.
module vx_uop_expander
    import vx_uop_expander_pkg::*;
#(
    parameter int UOP_DEPTH = UOP_DEPTH_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int NR_BITS   = NR_BITS_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int META_W    = META_W_DEF,
    localparam int UPC_BITS = $clog2(UOP_DEPTH),
    localparam int OUT_W    = META_W + CTRL_W + 4 * NR_BITS,
    localparam int ROM_W    = 2 + UPC_BITS + CNT_BITS + 5 * NR_BITS + CTRL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_uop_en_i,
    input  logic [UPC_BITS-1:0] in_entry_i,
    input  logic [OUT_W-1:0]    in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUT_W-1:0]    out_data_o,
    output logic                busy_o
);

    typedef struct packed {
        logic [1:0]          ubr;
        logic [UPC_BITS-1:0] target;
        logic [CNT_BITS-1:0] loop_cnt;
        logic [NR_BITS-1:0]  stride;
        logic [CTRL_W-1:0]   ctrl;
        logic [NR_BITS-1:0]  rd;
        logic [NR_BITS-1:0]  rs1;
        logic [NR_BITS-1:0]  rs2;
        logic [NR_BITS-1:0]  rs3;
    } rom_word_t;

    seq_state_e          state_q, state_d;
    logic [UPC_BITS-1:0] upc_q, upc_d;
    logic [CNT_BITS-1:0] iter_q, iter_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;

    logic [ROM_W-1:0]    rom_raw;
    rom_word_t           rom_word;
    logic                load_ok;
    logic [NR_BITS-2:0]  reloc_ofs;
    logic [OUT_W-1:0]    emit_word;

    vx_uop_rom #(
        .UOP_DEPTH (UOP_DEPTH),
        .CNT_BITS  (CNT_BITS),
        .NR_BITS   (NR_BITS),
        .CTRL_W    (CTRL_W)
    ) u_rom (
        .addr_i (upc_q),
        .word_o (rom_raw)
    );

    assign rom_word = rom_word_t'(rom_raw);

    // Relocation touches only the index bits; the register-file select MSB is kept.
    function automatic logic [NR_BITS-1:0] reloc(input logic [NR_BITS-1:0] idx,
                                                 input logic [NR_BITS-2:0] ofs);
        return {idx[NR_BITS-1], idx[NR_BITS-2:0] + ofs};
    endfunction

    assign reloc_ofs = (NR_BITS-1)'(NR_BITS'(iter_q) * rom_word.stride);
    assign emit_word = {meta_q, rom_word.ctrl,
                        reloc(rom_word.rd,  reloc_ofs), reloc(rom_word.rs1, reloc_ofs),
                        reloc(rom_word.rs2, reloc_ofs), reloc(rom_word.rs3, reloc_ofs)};

    assign load_ok     = !out_valid_q || out_ready_i;
    assign in_ready_o  = (state_q == ST_IDLE) && load_ok;
    assign busy_o      = (state_q == ST_SEQ);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        iter_d      = iter_q;
        meta_d      = meta_q;
        out_valid_d = out_ready_i ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    if (in_uop_en_i) begin
                        meta_d  = in_data_i[OUT_W-1 -: META_W];
                        upc_d   = in_entry_i;
                        iter_d  = '0;
                        state_d = ST_SEQ;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data_i;
                    end
                end
            end
            ST_SEQ: begin
                if (load_ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = emit_word;
                    case (rom_word.ubr)
                        UBR_NEXT: upc_d = rom_word.target;
                        UBR_LOOP: begin
                            if (iter_q != rom_word.loop_cnt) begin
                                iter_d = iter_q + 1'b1;
                                upc_d  = rom_word.target;
                            end else begin
                                iter_d = '0;
                                upc_d  = (upc_q == UPC_BITS'(UOP_DEPTH - 1)) ? '0 : upc_q + 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            upc_q       <= '0;
            iter_q      <= '0;
            meta_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            iter_q      <= iter_d;
            meta_q      <= meta_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_vx_uop_expander.sv
// Bench for vx_uop_expander: random stimulus scored against a table-driven
// sequence model of the tensor microcode.
module tb_vx_uop_expander;

    localparam int UOP_DEPTH = 64;
    localparam int CNT_BITS  = 3;
    localparam int NR_BITS   = 6;
    localparam int CTRL_W    = 80;
    localparam int META_W    = 48;
    localparam int UPC_BITS  = 6;
    localparam int OUT_W     = META_W + CTRL_W + 4 * NR_BITS;
    localparam int IDX_MOD   = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                in_uop_en_i;
    logic [UPC_BITS-1:0] in_entry_i;
    logic [OUT_W-1:0]    in_data_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [OUT_W-1:0]    out_data_o;
    logic                busy_o;

    always #5 clk = ~clk;

    vx_uop_expander #(
        .UOP_DEPTH (UOP_DEPTH),
        .CNT_BITS  (CNT_BITS),
        .NR_BITS   (NR_BITS),
        .CTRL_W    (CTRL_W),
        .META_W    (META_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_uop_en_i (in_uop_en_i),
        .in_entry_i  (in_entry_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference microcode table (ubr: 0 next, 1 finish, 2 loop, 3 reserved)
    int          m_ubr[UOP_DEPTH], m_tgt[UOP_DEPTH], m_cnt[UOP_DEPTH], m_stride[UOP_DEPTH];
    int          m_ctrl[UOP_DEPTH], m_rd[UOP_DEPTH], m_rs1[UOP_DEPTH], m_rs2[UOP_DEPTH], m_rs3[UOP_DEPTH];

    logic                q_en[$];
    logic [UPC_BITS-1:0] q_entry[$];
    logic [OUT_W-1:0]    q_data[$];
    logic [OUT_W-1:0]    exp_q[$];
    logic [OUT_W-1:0]    got_q[$];
    int                  acc_cyc[$];
    int                  out_cyc[$];

    task automatic set_ent(input int a, input int ubr, input int tgt, input int cnt, input int stride,
                           input int ctrl, input int rd, input int rs1, input int rs2, input int rs3);
        m_ubr[a] = ubr; m_tgt[a] = tgt; m_cnt[a] = cnt; m_stride[a] = stride; m_ctrl[a] = ctrl;
        m_rd[a] = rd; m_rs1[a] = rs1; m_rs2[a] = rs2; m_rs3[a] = rs3;
    endtask

    task automatic init_model();
        for (int i = 0; i < UOP_DEPTH; i++) set_ent(i, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ent(0,  0, 8,  0, 0, 'h111,  1,  2,  3,  4);
        set_ent(8,  1, 0,  0, 0, 'h222,  5,  6,  7,  8);
        set_ent(20, 2, 20, 3, 2, 'h333, 16, 33, 10,  0);
        set_ent(21, 1, 0,  0, 0, 'h444,  9, 10, 11, 12);
        set_ent(30, 3, 5,  0, 0, 'h666, 13, 14, 15, 16);
        set_ent(63, 2, 63, 1, 3, 'h555, 62, 31,  0, 45);
    endtask

    function automatic int reloc(input int idx, input int it, input int stride);
        return (idx / IDX_MOD) * IDX_MOD + ((idx % IDX_MOD) + it * stride) % IDX_MOD;
    endfunction

    function automatic logic [OUT_W-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[OUT_W-1:0];
    endfunction

    task automatic expand(input int entry, input logic [META_W-1:0] meta);
        int upc = entry;
        int it  = 0;
        for (int n = 0; n < 200; n++) begin
            exp_q.push_back({meta, CTRL_W'(m_ctrl[upc]),
                             NR_BITS'(reloc(m_rd[upc],  it, m_stride[upc])),
                             NR_BITS'(reloc(m_rs1[upc], it, m_stride[upc])),
                             NR_BITS'(reloc(m_rs2[upc], it, m_stride[upc])),
                             NR_BITS'(reloc(m_rs3[upc], it, m_stride[upc]))});
            if (m_ubr[upc] == 0) upc = m_tgt[upc];
            else if (m_ubr[upc] == 2) begin
                if (it != m_cnt[upc]) begin it++; upc = m_tgt[upc]; end
                else begin it = 0; upc = (upc + 1) % UOP_DEPTH; end
            end else break;
        end
    endtask

    task automatic clear_logs();
        q_en.delete(); q_entry.delete(); q_data.delete();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
    endtask

    task automatic push_instr(input logic en, input int entry);
        q_en.push_back(en);
        q_entry.push_back(UPC_BITS'(entry));
        q_data.push_back(rand_word());
    endtask

    // Drives the queued instructions, scores every handshake, and checks stalls.
    task automatic run_stream(input int ready_pct, input int budget);
        int               n = 0;
        logic             stall_prev = 1'b0;
        logic [OUT_W-1:0] prev_data = '0;
        while ((q_en.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clk);
            out_ready_i = ($urandom_range(99) < ready_pct);
            if (q_en.size() > 0) begin
                in_valid_i = 1'b1; in_uop_en_i = q_en[0]; in_entry_i = q_entry[0]; in_data_i = q_data[0];
            end else begin
                in_valid_i = 1'b0; in_uop_en_i = 1'b0; in_data_i = rand_word();
            end
            #1;
            if (busy_o && in_ready_o) begin
                tests_run++; tests_failed++;
                $display("FAIL in_ready_during_seq: in_ready=%0b busy=%0b, need in_ready=0", in_ready_o, busy_o);
            end
            if (stall_prev) begin
                tests_run++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
                    tests_failed++;
                    $display("FAIL stall_hold: valid=%0b data=%h, need valid=1 data=%h", out_valid_o, out_data_o, prev_data);
                end
            end
            if (out_valid_o && out_ready_i) begin
                tests_run++;
                got_q.push_back(out_data_o);
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_output: got %h, need no output", out_data_o);
                end else begin
                    logic [OUT_W-1:0] e = exp_q.pop_front();
                    if (out_data_o !== e) begin
                        tests_failed++;
                        $display("FAIL out_word: got %h, need %h", out_data_o, e);
                    end
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            if (in_valid_i && in_ready_o) begin
                if (q_en[0]) expand(int'(q_entry[0]), q_data[0][OUT_W-1 -: META_W]);
                else exp_q.push_back(q_data[0]);
                acc_cyc.push_back(cyc);
                void'(q_en.pop_front()); void'(q_entry.pop_front()); void'(q_data.pop_front());
            end
            cyc++;
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL stream_timeout: %0d instrs and %0d outputs pending, need 0", q_en.size(), exp_q.size());
        end
        @(negedge clk);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: valid=%0b busy=%0b, need 0 0", out_valid_o, busy_o);
        end
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid_i = 1'b0; in_uop_en_i = 1'b0; in_entry_i = '0; in_data_i = '0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0b busy=%0b in_ready=%0b, need 0 0 1", out_valid_o, busy_o, in_ready_o);
        end
    endtask

    task automatic test_passthrough();
        logic [OUT_W-1:0] prev = '0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            out_ready_i = 1'b1; in_uop_en_i = 1'b0;
            in_valid_i = (k < 4);
            in_data_i = rand_word();
            #1;
            if (k < 4) begin
                tests_run++;
                if (in_ready_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL pass_in_ready: got %0b, need 1", in_ready_o);
                end
            end
            if (k > 0) begin
                tests_run++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev) begin
                    tests_failed++;
                    $display("FAIL pass_word%0d: valid=%0b data=%h, need 1 %h", k - 1, out_valid_o, out_data_o, prev);
                end
            end
            prev = in_data_i;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_macro();
        clear_logs();
        push_instr(1'b1, 0);
        push_instr(1'b1, 0);
        run_stream(100, 100);
        tests_run++;
        if (got_q.size() != 4 || acc_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL macro_count: got %0d uops %0d accepts, need 4 2", got_q.size(), acc_cyc.size());
        end else begin
            tests_run++;
            if (out_cyc[0] != acc_cyc[0] + 2 || acc_cyc[1] != out_cyc[1] || out_cyc[2] != acc_cyc[1] + 2) begin
                tests_failed++;
                $display("FAIL macro_timing: acc %0d/%0d out %0d/%0d/%0d, need out0=acc0+2 acc1=out1 out2=acc1+2",
                         acc_cyc[0], acc_cyc[1], out_cyc[0], out_cyc[1], out_cyc[2]);
            end
        end
    endtask

    task automatic test_loop();
        int exp_rd[5] = '{16, 18, 20, 22, 9};
        clear_logs();
        push_instr(1'b1, 20);
        run_stream(100, 100);
        tests_run++;
        if (got_q.size() != 5) begin
            tests_failed++;
            $display("FAIL loop_count: got %0d, need 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (int'(got_q[i][23:18]) != exp_rd[i]) begin
                    tests_failed++;
                    $display("FAIL loop_rd%0d: got %0d, need %0d", i, got_q[i][23:18], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        clear_logs();
        push_instr(1'b1, 20);
        push_instr(1'b0, 0);
        push_instr(1'b1, 20);
        run_stream(30, 600);
        tests_run++;
        if (got_q.size() != 11) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d, need 11", got_q.size());
        end
        clear_logs();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            int pick = $urandom_range(5);
            int ent  = (pick == 1) ? 20 : (pick == 2) ? 63 : (pick == 3) ? 30 : (pick == 4) ? 40 : 0;
            push_instr(pick != 5, ent);
        end
        run_stream(50, 2000);
    endtask

    task automatic test_wrap();
        clear_logs();
        push_instr(1'b1, 63);
        run_stream(100, 100);
        tests_run++;
        if (got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d, need 4", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0][23:18] !== 6'd62 || got_q[1][23:18] !== 6'd33 || got_q[2][103:24] !== 80'h111) begin
                tests_failed++;
                $display("FAIL wrap_fields: rd0=%0d rd1=%0d ctrl2=%h, need 62 33 111",
                         got_q[0][23:18], got_q[1][23:18], got_q[2][103:24]);
            end
        end
    endtask

    task automatic test_reserved();
        clear_logs();
        push_instr(1'b1, 30);
        push_instr(1'b1, 40);
        run_stream(100, 100);
        tests_run++;
        if (got_q.size() != 2) begin
            tests_failed++;
            $display("FAIL rsvd_count: got %0d, need 2", got_q.size());
        end else begin
            tests_run++;
            if (got_q[1][103:0] !== 104'd0) begin
                tests_failed++;
                $display("FAIL unlisted_payload: got %h, need 0", got_q[1][103:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_logs();
        @(negedge clk);
        out_ready_i = 1'b1; in_valid_i = 1'b1; in_uop_en_i = 1'b1; in_entry_i = UPC_BITS'(20);
        in_data_i = rand_word();
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_accept: in_ready=%0b, need 1", in_ready_o);
        end
        expand(20, in_data_i[OUT_W-1 -: META_W]);
        for (int n = 0; n < 20 && k < 2; n++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            #1;
            if (out_valid_o) begin
                logic [OUT_W-1:0] e = exp_q.pop_front();
                tests_run++;
                if (out_data_o !== e) begin
                    tests_failed++;
                    $display("FAIL rmid_word%0d: got %h, need %h", k, out_data_o, e);
                end
                k++;
            end
        end
        tests_run++;
        if (k < 2) begin
            tests_failed++;
            $display("FAIL rmid_timeout: got %0d uops, need 2", k);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_reset: valid=%0b busy=%0b, need 0 0", out_valid_o, busy_o);
        end
        reset = 1'b0;
        clear_logs();
        push_instr(1'b1, 20);
        run_stream(100, 100);
        tests_run++;
        if (got_q.size() != 5 || got_q[0][23:18] !== 6'd16) begin
            tests_failed++;
            $display("FAIL rmid_restart: count=%0d, need 5 starting at rd 16", got_q.size());
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_passthrough();
        test_macro();
        test_loop();
        test_backpressure();
        test_wrap();
        test_reserved();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
